// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;
    localparam logic [3:0] OP_SAR  = 4'd12;
    localparam logic [3:0] OP_MOV  = 4'd15;

    localparam int NFLAGS       = 5;
    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_CARRY   = 2;
    localparam int FLAG_OVF     = 3;
    localparam int FLAG_ILLEGAL = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [NFLAGS-1:0] pack_flags(input logic ill, input logic ovf,
                                                     input logic carry, input logic neg,
                                                     input logic zero);
        logic [NFLAGS-1:0] f;
        f               = '0;
        f[FLAG_ILLEGAL] = ill;
        f[FLAG_OVF]     = ovf;
        f[FLAG_CARRY]   = carry;
        f[FLAG_NEG]     = neg;
        f[FLAG_ZERO]    = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU; master = requester, slave = ALU.
interface alu_mc_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  operand_a;
    logic [WIDTH-1:0]  operand_b;
    logic [3:0]        alu_op;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic [NFLAGS-1:0] flags;

    modport master (
        output in_valid, operand_a, operand_b, alu_op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, operand_a, operand_b, alu_op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one hi:lo register pair.
// start_i loads the operands and performs the first step, so done_o rises WIDTH-1 cycles later.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic             busy_q, is_div_q, is_rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opd_q, hi_q, lo_q;

    logic             src_div;
    logic [WIDTH-1:0] src_hi, src_lo, src_opd, hi_d, lo_d;
    logic [WIDTH:0]   add_sum, shifted, diff;

    // Multiply: hi:lo = {0, b}, opd = a.  Divide: hi = remainder, lo = a shifting into quotient, opd = b.
    always_comb begin
        src_div = start_i ? (op_i != OP_MUL) : is_div_q;
        src_hi  = start_i ? '0 : hi_q;
        src_lo  = start_i ? (src_div ? a_i : b_i) : lo_q;
        src_opd = start_i ? (src_div ? b_i : a_i) : opd_q;
        add_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opd} : '0);
        shifted = {src_hi, src_lo[WIDTH-1]};
        diff    = shifted - {1'b0, src_opd};
        if (!src_div) begin
            hi_d = add_sum[WIDTH:1];
            lo_d = {add_sum[0], src_lo[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {src_lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = shifted[WIDTH-1:0];
            lo_d = {src_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            cnt_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            is_div_q <= src_div;
            is_rem_q <= (op_i == OP_REMU);
            cnt_q    <= CW'(1);
            opd_q    <= src_opd;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                hi_q  <= hi_d;
                lo_q  <= lo_d;
            end
        end
    end

    // Division by zero falls out of the algorithm as quotient all-ones, remainder a.
    assign done_o     = busy_q && (cnt_q == LAST);
    assign result_o   = is_rem_q ? hi_q : lo_q;
    assign overflow_o = is_div_q ? (opd_q == '0) : (|hi_q);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and result channels.
// Define ALU_MULDIV_EN to add the iterative MUL/DIVU/REMU unit; otherwise those opcodes are illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [NFLAGS-1:0] flags_q, flags_d;

    logic              in_ready, accept, is_iter;
    logic              alu_c, alu_ov, alu_ill;
    logic [WIDTH-1:0]  a, b, alu_res;
    logic [WIDTH:0]    add_w, sub_w;

    assign a      = bus.operand_a;
    assign b      = bus.operand_b;
    assign add_w  = {1'b0, a} + {1'b0, b};
    assign sub_w  = {1'b0, a} - {1'b0, b};
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept = bus.in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        is_iter = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_SAR: alu_res = $signed(a) >>> b[SW-1:0];
            OP_MOV: alu_res = b;
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIVU, OP_REMU: is_iter = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             iter_done, iter_ov;
    logic [WIDTH-1:0] iter_res;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept && is_iter),
        .op_i       (bus.alu_op),
        .a_i        (a),
        .b_i        (b),
        .done_o     (iter_done),
        .result_o   (iter_res),
        .overflow_o (iter_ov)
    );
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: ;
`ifdef ALU_MULDIV_EN
            BUSY: if (iter_done) begin
                state_d  = DONE;
                result_d = iter_res;
                flags_d  = pack_flags(1'b0, iter_ov, 1'b0, iter_res[WIDTH-1], iter_res == '0);
            end
`endif
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new request can only be accepted from IDLE or during the DONE handoff.
        if (accept) begin
            if (is_iter) begin
                state_d = BUSY;
            end else begin
                state_d  = DONE;
                result_d = alu_res;
                flags_d  = pack_flags(alu_ill, alu_ov, alu_c, alu_res[WIDTH-1], alu_res == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule
